// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared fetch types and constants
package riscv_fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush and level
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o     = (r_level == (AW+1)'(DEPTH));
  assign empty_o    = (r_level == '0);
  assign level_o    = r_level;
  assign pop_data_o = r_mem[r_rptr];

  assign w_do_pop  = pop_i && !empty_o && !flush_i;
  assign w_do_push = push_i && !flush_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= push_data_i;
  end

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - pipelined instruction prefetch with redirect flush
// Credit-based issue keeps outstanding requests plus FIFO occupancy within FIFO_DEPTH.
module instr_prefetch
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN            = FETCH_XLEN,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  output logic                          imem_req_valid_o,
  input  logic                          imem_req_ready_i,
  output logic [XLEN-1:0]               imem_req_addr_o,
  input  logic                          imem_rsp_valid_i,
  input  logic [XLEN-1:0]               imem_rsp_data_i,
  input  logic                          redirect_en_i,
  input  logic [XLEN-1:0]               redirect_addr_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [XLEN-1:0]               instr_o,
  output logic [XLEN-1:0]               pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic            r_run;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [OW-1:0]   r_out;
  logic [OW-1:0]   r_drop;

  logic [LW-1:0]   w_level;
  logic [LW:0]     w_credit_sum;
  logic            w_full;
  logic            w_empty;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_rsp;
  logic            w_keep;
  logic            w_pop;
  logic [OW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redirect_pc;
  entry_t          w_push_entry;
  entry_t          w_head;

  assign w_credit_sum  = (LW+1)'(r_out) + (LW+1)'(w_level);
  assign w_req_valid   = r_run && (r_out < OW'(MAX_OUTSTANDING))
                         && (w_credit_sum < (LW+1)'(FIFO_DEPTH));
  assign w_fire        = w_req_valid && imem_req_ready_i;
  // A response with nothing outstanding is illegal and simply ignored.
  assign w_rsp         = imem_rsp_valid_i && (r_out != '0);
  assign w_keep        = w_rsp && (r_drop == '0) && !redirect_en_i;
  assign w_pop         = !w_empty && instr_ready_i && !redirect_en_i;
  assign w_out_next    = r_out + OW'(w_fire) - OW'(w_rsp);
  assign w_redirect_pc = redirect_addr_i & ~XLEN'(3);
  assign w_push_entry  = '{pc: r_rsp_pc, instr: imem_rsp_data_i};

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .push_i      (w_keep),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (redirect_en_i),
    .pop_data_o  (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (w_level)
  );

  // On redirect everything still in flight after this cycle becomes stale.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_run    <= 1'b0;
      r_req_pc <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
    end else begin
      r_run <= 1'b1;
      r_out <= w_out_next;
      if (redirect_en_i) begin
        r_req_pc <= w_redirect_pc;
        r_rsp_pc <= w_redirect_pc;
        r_drop   <= w_out_next;
      end else begin
        if (w_fire) r_req_pc <= r_req_pc + XLEN'(PC_STEP);
        if (w_keep) r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - OW'(1);
      end
    end
  end

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_req_pc;
  assign instr_valid_o    = !w_empty;
  assign instr_o          = w_empty ? XLEN'(NOP_INSTR) : w_head.instr;
  assign pc_o             = w_empty ? '0 : w_head.pc;
  assign fifo_level_o     = w_level;

  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (!resetn_i)
    !(imem_rsp_valid_i && (r_out == '0)));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!resetn_i)
    !(w_keep && w_full && !w_pop));

endmodule
